mutex_bank: RTL and testbench

//  Avalon-MM slave holding NUM_MUTEX independent hardware mutexes for multi-NIOS image processing.

---
 rtl/mutex_bank.sv | 142 ++++++++++++++
 tb/tb_mutex_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mutex_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mutex_bank : Avalon-MM bank of hardware mutexes with a release-event irq. |
// | Optional hold watchdog when MUTEX_TIMEOUT_EN is defined.  Rev 1.0         |
// +--------------------------------------------------------------------------+
module mutex_bank #(
  parameter int NUM_MUTEX      = 4,
  parameter int OWNER_W        = 16,
  parameter int VALUE_W        = 16,
  parameter int INIT_OWNER     = 0,
  parameter int INIT_VALUE     = 0,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int AW            = $clog2(NUM_MUTEX + 3)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          chipselect,
  input  logic [AW-1:0] address,
  input  logic          read,
  input  logic          write,
  input  logic [31:0]   data_from_cpu,
  output logic [31:0]   data_to_cpu,
  output logic          irq
);

  localparam logic [AW-1:0]      c_ADDR_FLAG   = AW'(NUM_MUTEX);
  localparam logic [AW-1:0]      c_ADDR_LOCKED = AW'(NUM_MUTEX + 1);
  localparam logic [AW-1:0]      c_ADDR_EVENT  = AW'(NUM_MUTEX + 2);
  localparam logic [VALUE_W-1:0] c_INIT_VALUE  = VALUE_W'(INIT_VALUE);
  localparam logic [OWNER_W-1:0] c_INIT_OWNER  = OWNER_W'(INIT_OWNER);

  logic [VALUE_W-1:0]   r_value [NUM_MUTEX];
  logic [OWNER_W-1:0]   r_owner [NUM_MUTEX];
  logic [NUM_MUTEX-1:0] r_event;
  logic                 r_reset_flag;
  logic                 r_irq;

  logic [NUM_MUTEX-1:0] w_locked;
  logic [NUM_MUTEX-1:0] w_release;
  logic                 w_bus_wr;
  logic [VALUE_W-1:0]   w_wval;
  logic [OWNER_W-1:0]   w_wown;
  logic                 w_unused_ok;

  assign w_bus_wr    = chipselect & write;
  assign w_wval      = data_from_cpu[VALUE_W-1:0];
  assign w_wown      = data_from_cpu[VALUE_W +: OWNER_W];
  assign w_unused_ok = &{1'b0, read, data_from_cpu};

`ifndef MUTEX_TIMEOUT_EN
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
`endif

  generate
    for (genvar k = 0; k < NUM_MUTEX; k++) begin : g_mutex
      logic               w_wr;
      logic               w_en;
      logic               w_expire;
      logic [VALUE_W-1:0] w_next_value;

      assign w_wr = w_bus_wr && (address == AW'(k));
      assign w_en = w_wr && ((r_value[k] == '0) || (r_owner[k] == w_wown));

`ifdef MUTEX_TIMEOUT_EN
      localparam int           CW             = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] c_TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES);
      logic [CW-1:0] r_count;

      assign w_expire = (r_value[k] != '0) && (r_count == CW'(1));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_count <= (c_INIT_VALUE != '0) ? c_TIMEOUT_LOAD : '0;
        end else if (w_en) begin
          r_count <= (w_wval != '0) ? c_TIMEOUT_LOAD : '0;
        end else if ((r_value[k] != '0) && (r_count != '0)) begin
          r_count <= r_count - CW'(1);
        end
      end
`else
      assign w_expire = 1'b0;
`endif

      // An enabled write takes precedence over a simultaneous expiry.
      always_comb begin
        w_next_value = r_value[k];
        if (w_en)          w_next_value = w_wval;
        else if (w_expire) w_next_value = '0;
      end

      assign w_locked[k]  = (r_value[k] != '0);
      assign w_release[k] = w_locked[k] && (w_next_value == '0);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_value[k] <= c_INIT_VALUE;
          r_owner[k] <= c_INIT_OWNER;
        end else if (w_en) begin
          r_value[k] <= w_wval;
          r_owner[k] <= w_wown;
        end else if (w_expire) begin
          r_value[k] <= '0;
          r_owner[k] <= '0;
        end
      end
    end
  endgenerate

  // New release events win over a same-cycle W1C clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_event      <= '0;
      r_reset_flag <= 1'b1;
      r_irq        <= 1'b0;
    end else begin
      if (w_bus_wr && (address == c_ADDR_EVENT))
        r_event <= (r_event & ~data_from_cpu[NUM_MUTEX-1:0]) | w_release;
      else
        r_event <= r_event | w_release;
      if (w_bus_wr && (address == c_ADDR_FLAG))
        r_reset_flag <= 1'b0;
      r_irq <= |r_event;
    end
  end

  always_comb begin
    data_to_cpu = '0;
    for (int k = 0; k < NUM_MUTEX; k++) begin
      if (address == AW'(k)) begin
        data_to_cpu[VALUE_W-1:0]       = r_value[k];
        data_to_cpu[VALUE_W +: OWNER_W] = r_owner[k];
      end
    end
    if (address == c_ADDR_FLAG)   data_to_cpu[0]             = r_reset_flag;
    if (address == c_ADDR_LOCKED) data_to_cpu[NUM_MUTEX-1:0] = w_locked;
    if (address == c_ADDR_EVENT)  data_to_cpu[NUM_MUTEX-1:0] = r_event;
  end

  assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_mutex_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mutex_bank : table-driven bench for mutex_bank (4 mutexes, 16/16 bit). |
// | Timeout sequences apply when MUTEX_TIMEOUT_EN is defined.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module tb_mutex_bank;

  logic        clk;
  logic        reset_n;
  logic        chipselect;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] data_from_cpu;
  logic [31:0] data_to_cpu;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_rd;
    logic [2:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_exp[$];
  string       sb_name[$];

  mutex_bank #(
    .NUM_MUTEX(4), .OWNER_W(16), .VALUE_W(16),
    .INIT_OWNER(0), .INIT_VALUE(0), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .read(read), .write(write), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Write is driven for exactly one rising edge.
  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; data_from_cpu = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    sb_exp.push_back(exp);
    sb_name.push_back(name);
    #1;
    check(sb_name.pop_front(), data_to_cpu, sb_exp.pop_front());
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic add(input bit rd, input logic [2:0] a, input logic [31:0] d);
    vec_t v;
    v.is_rd = rd; v.addr = a; v.data = d;
    vecs.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; data_from_cpu = '0;

    // reset state and RESET_FLAG
    for (int a = 0; a < 8; a++) add(1, 3'(a), (a == 4) ? 32'h1 : 32'h0);
    add(0, 3'd4, 32'hFFFF_FFFF); add(1, 3'd4, 32'h0);
    // acquire, RO LOCKED, owner mismatch, owner refresh
    add(0, 3'd1, 32'h0001_0005); add(1, 3'd1, 32'h0001_0005); add(1, 3'd5, 32'h2);
    add(0, 3'd5, 32'hF);         add(1, 3'd5, 32'h2);
    add(0, 3'd1, 32'h0002_0007); add(1, 3'd1, 32'h0001_0005);
    add(0, 3'd1, 32'h0001_0009); add(1, 3'd1, 32'h0001_0009);

    repeat (3) @(negedge clk);
    check("reset_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_rd) do_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      else               do_write(vecs[i].addr, vecs[i].data);
    end

    // release by owner: EVENT set, irq one cycle later, W1C clears both
    do_write(3'd1, 32'h0001_0000);
    check("irq_not_yet", {31'd0, irq}, 32'h0);
    @(posedge clk); #1;
    check("irq_set", {31'd0, irq}, 32'h1);
    do_read(3'd1, 32'h0001_0000, "rel_value");
    do_read(3'd5, 32'h0,         "rel_locked");
    do_read(3'd6, 32'h2,         "rel_event");
    do_write(3'd6, 32'h2);
    check("irq_lag", {31'd0, irq}, 32'h1);
    @(posedge clk); #1;
    check("irq_clr", {31'd0, irq}, 32'h0);
    do_read(3'd6, 32'h0, "event_clr");

    // two mutexes with distinct owners, release only one
    vecs.delete();
    add(0, 3'd0, 32'h000A_0003); add(0, 3'd3, 32'h000B_0004); add(0, 3'd3, 32'h000B_0000);
    add(1, 3'd0, 32'h000A_0003); add(1, 3'd5, 32'h1);         add(1, 3'd6, 32'h8);
    add(0, 3'd0, 32'h000B_0000); add(1, 3'd0, 32'h000A_0003);
    add(0, 3'd0, 32'h000A_0000); add(1, 3'd5, 32'h0);         add(1, 3'd6, 32'h9);
    add(0, 3'd6, 32'hF);         add(1, 3'd6, 32'h0);
    add(0, 3'd7, 32'h1234_5678); add(1, 3'd7, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_rd) do_read(vecs[i].addr, vecs[i].data, $sformatf("two%0d", i));
      else               do_write(vecs[i].addr, vecs[i].data);
    end

`ifdef MUTEX_TIMEOUT_EN
    // plain expiry exactly 8 edges after acquisition
    do_write(3'd2, 32'h0003_0001);
    repeat (7) @(negedge clk);
    do_read(3'd2, 32'h0003_0001, "to_held7");
    do_read(3'd2, 32'h0,         "to_expired8");
    do_read(3'd6, 32'h4,         "to_event");
    do_write(3'd6, 32'hF);
    // refresh on cycle 6 pushes expiry out
    do_write(3'd2, 32'h0003_0001);
    repeat (5) @(negedge clk);
    do_write(3'd2, 32'h0003_0002);
    repeat (7) @(negedge clk);
    do_read(3'd2, 32'h0003_0002, "rf_held7");
    do_read(3'd2, 32'h0,         "rf_expired8");
    do_write(3'd6, 32'hF);
    // write on the expiry edge wins and reloads
    do_write(3'd2, 32'h0003_0001);
    repeat (7) @(negedge clk);
    do_write(3'd2, 32'h0003_0005);
    do_read(3'd2, 32'h0003_0005, "ex_write_wins");
    do_read(3'd6, 32'h0,         "ex_no_event");
    repeat (5) @(negedge clk);
    do_read(3'd2, 32'h0003_0005, "ex_held7");
    do_read(3'd2, 32'h0,         "ex_expired8");
    do_write(3'd6, 32'hF);
`else
    do_write(3'd2, 32'h0003_0001);
    repeat (20) @(negedge clk);
    do_read(3'd2, 32'h0003_0001, "no_timeout_held");
    do_write(3'd2, 32'h0003_0000);
    do_read(3'd2, 32'h0003_0000, "no_timeout_rel");
    do_write(3'd6, 32'hF);
`endif

    // asynchronous reset while held with irq pending
    do_write(3'd3, 32'h000C_0001);
    do_write(3'd0, 32'h000A_0003);
    do_write(3'd3, 32'h000C_0000);
    @(posedge clk); #1;
    check("pre_rst_irq", {31'd0, irq}, 32'h1);
    @(negedge clk); #2;
    chipselect = 1'b1; read = 1'b1; address = 3'd0;
    reset_n = 1'b0;
    #1 check("arst_mutex0", data_to_cpu, 32'h0);
    check("arst_irq", {31'd0, irq}, 32'h0);
    address = 3'd4;
    #1 check("arst_flag", data_to_cpu, 32'h1);
    address = 3'd5;
    #1 check("arst_locked", data_to_cpu, 32'h0);
    address = 3'd6;
    #1 check("arst_event", data_to_cpu, 32'h0);
    chipselect = 1'b0; read = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_read(3'd0, 32'h0, "post_rst_mutex0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
